// File: rtl/multi_button_debouncer.sv
// N-channel key debouncer: 2-flop sync, polarity normalise, debounce counter, press/long/release FSM.
// Latency: clean pin edge -> btn_level and pulse after 2+DEBOUNCE_CYCLES cycles; all outputs registered.
// Backpressure: none; free-running pulse outputs. Optional auto-repeat in HELD via `define AUTO_REPEAT_EN.
module multi_button_debouncer #(
    parameter int NUM_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int REPEAT_CYCLES     = 10000000,
    parameter int ACTIVE_LOW        = 1,
    parameter int CNT_W             = 26
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn_in,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] long_pulse
);

    // Pin level that means "not pressed"; also the XOR mask that makes 1 = pressed.
    localparam logic             REL_LVL   = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    // Configuration sanity: counters must never need to wrap.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 2");
    end
    if ((longint'(1) << CNT_W) <= longint'(LONG_PRESS_CYCLES) ||
        (longint'(1) << CNT_W) <= longint'(REPEAT_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for the configured cycle counts");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_e;

    logic [NUM_BUTTONS-1:0] sync1_q;
    logic [NUM_BUTTONS-1:0] sync2_q;

    // Two-flop synchroniser; reset parks it at the released pin level so no false edge appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= {NUM_BUTTONS{REL_LVL}};
            sync2_q <= {NUM_BUTTONS{REL_LVL}};
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        logic             s;
        logic             stable_q;
        logic             stable_d;
        logic [CNT_W-1:0] deb_cnt_q;
        logic [CNT_W-1:0] deb_cnt_d;
        logic             deb_done;
        logic             acc_press;
        logic             acc_release;
        state_e           state_q;
        logic [CNT_W-1:0] hold_cnt_q;
        logic             press_q;
        logic             release_q;
        logic             long_q;

        assign s           = sync2_q[i] ^ REL_LVL;
        assign deb_done    = (s != stable_q) && (deb_cnt_q == DEB_LAST);
        assign acc_press   = deb_done && s;
        assign acc_release = deb_done && !s;

        // Debounce next state: count while input disagrees, any agreement restarts the count.
        always_comb begin
            stable_d  = stable_q;
            deb_cnt_d = '0;
            if (s != stable_q) begin
                if (deb_done) begin
                    stable_d  = s;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
        end

        // Debounce state registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                stable_q  <= 1'b0;
                deb_cnt_q <= '0;
            end else begin
                stable_q  <= stable_d;
                deb_cnt_q <= deb_cnt_d;
            end
        end

        // Press FSM with registered one-cycle pulses; release outranks long/repeat.
        always_ff @(posedge clk) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            if (reset) begin
                state_q    <= IDLE;
                hold_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        hold_cnt_q <= '0;
                        if (acc_press) begin
                            state_q <= PRESSED;
                            press_q <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (acc_release) begin
                            state_q    <= IDLE;
                            release_q  <= 1'b1;
                            hold_cnt_q <= '0;
                        end else if (hold_cnt_q == LONG_LAST) begin
                            state_q    <= HELD;
                            long_q     <= 1'b1;
                            hold_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (acc_release) begin
                            state_q    <= IDLE;
                            release_q  <= 1'b1;
                            hold_cnt_q <= '0;
                        end
`ifdef AUTO_REPEAT_EN
                        else if (hold_cnt_q == REP_LAST) begin
                            press_q    <= 1'b1;
                            hold_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                        end
`endif
                    end
                    default: begin
                        state_q    <= IDLE;
                        hold_cnt_q <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i]     = stable_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
    end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer with short cycle counts.
// Inputs change 1 time unit after a rising edge; outputs sampled at the same point.
// Observation vector: {btn_level, press_pulse, release_pulse, long_pulse}, 2 bits each.
module tb_multi_button_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn_in;
    logic [1:0] btn_level;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] long_pulse;

    int errors = 0;
    int checks = 0;

    multi_button_debouncer #(
        .NUM_BUTTONS      (2),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .REPEAT_CYCLES    (8),
        .ACTIVE_LOW       (1),
        .CNT_W            (26)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {btn_level, press_pulse, release_pulse, long_pulse};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 2'b11;

        // Reset held 50 cycles with keys released: everything quiet.
        for (int k = 0; k < 50; k++) begin
            tick(1);
            chk("reset_hold", 8'h00);
        end
        reset = 1'b0;
        tick(10);
        chk("post_reset_idle", 8'h00);

        // Channel 0 press: pulse exactly at T+6, then release 6 cycles after rising edge.
        btn_in = 2'b10;
        tick(5);
        chk("ch0_press_T5", 8'h00);
        tick(1);
        chk("ch0_press_T6", 8'h50);
        tick(1);
        chk("ch0_press_T7", 8'h40);
        tick(3);
        btn_in = 2'b11;
        tick(5);
        chk("ch0_rel_R5", 8'h40);
        tick(1);
        chk("ch0_rel_R6", 8'h04);
        tick(1);
        chk("ch0_rel_R7", 8'h00);
        tick(10);

        // Bounce: 3 cycles low, 3 high, five times -> never accepted.
        for (int k = 0; k < 5; k++) begin
            btn_in = 2'b10;
            tick(3);
            btn_in = 2'b11;
            tick(3);
            chk("bounce", 8'h00);
        end
        tick(10);
        chk("bounce_settled", 8'h00);

        // Channel 1 long hold of 40 cycles.
        btn_in = 2'b01;
        tick(6);
        chk("ch1_press_T6", 8'hA0);
        tick(1);
        chk("ch1_hold_T7", 8'h80);
        tick(18);
        chk("ch1_hold_T25", 8'h80);
        tick(1);
        chk("ch1_long_T26", 8'h82);
        tick(1);
        chk("ch1_held_T27", 8'h80);
        tick(6);
        chk("ch1_held_T33", 8'h80);
        tick(1);
`ifdef AUTO_REPEAT_EN
        chk("ch1_repeat_T34", 8'hA0);
`else
        chk("ch1_norepeat_T34", 8'h80);
`endif
        tick(6);
        chk("ch1_held_T40", 8'h80);
        btn_in = 2'b11;
        tick(2);
`ifdef AUTO_REPEAT_EN
        chk("ch1_repeat_T42", 8'hA0);
`else
        chk("ch1_norepeat_T42", 8'h80);
`endif
        tick(3);
        chk("ch1_rel_R5", 8'h80);
        tick(1);
        chk("ch1_rel_R6", 8'h08);
        tick(1);
        chk("ch1_rel_R7", 8'h00);
        tick(10);

        // Both channels at once, then reset mid-hold and re-report after reset drops.
        btn_in = 2'b00;
        tick(6);
        chk("both_press", 8'hF0);
        tick(1);
        chk("both_hold", 8'hC0);
        tick(5);
        reset = 1'b1;
        tick(1);
        chk("mid_reset_1", 8'h00);
        tick(3);
        chk("mid_reset_4", 8'h00);
        reset = 1'b0;
        tick(5);
        chk("rereport_R5", 8'h00);
        tick(1);
        chk("rereport_R6", 8'hF0);
        tick(1);
        chk("rereport_R7", 8'hC0);
        tick(4);
        btn_in = 2'b11;
        tick(6);
        chk("both_release", 8'h0C);
        tick(1);
        chk("both_idle", 8'h00);
        tick(10);

        // Release accepted on the same cycle the hold counter would fire long.
        btn_in = 2'b10;
        tick(6);
        chk("race_press_T6", 8'h50);
        tick(14);
        chk("race_hold_T20", 8'h40);
        btn_in = 2'b11;
        tick(5);
        chk("race_T25", 8'h40);
        tick(1);
        chk("race_T26_release_only", 8'h04);
        tick(1);
        chk("race_T27", 8'h00);
        tick(20);
        chk("race_quiet", 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_button_debouncer.md
Name: multi_button_debouncer

Overview:
- N-channel successor to the single-key debounce/pulse shaper used on the board KEY inputs.
- Per channel: 2-flop synchroniser, polarity normalisation, debounce counter, and a 3-state press FSM producing press, release and long-press pulses.
- Sits between raw KEY pins and the control FSMs. Optional auto-repeat for menu/up-down style controls.

Parameters:
NUM_BUTTONS, 4, number of independent channels (>=1)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a change (10 ms @ 50 MHz, >=2)
LONG_PRESS_CYCLES, 50000000, cycles a press must be held before long_pulse fires (1 s @ 50 MHz, >DEBOUNCE_CYCLES)
REPEAT_CYCLES, 10000000, auto-repeat period in HELD (used only with AUTO_REPEAT_EN, >=2)
ACTIVE_LOW, 1, 1: pin low = pressed (KEY style); 0: pin high = pressed
CNT_W, 26, counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, REPEAT_CYCLES)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous reset, active-high
btn_in  input  NUM_BUTTONS  raw asynchronous button pins
btn_level  output  NUM_BUTTONS  debounced level, 1 = pressed (polarity-normalised)
press_pulse  output  NUM_BUTTONS  1-cycle pulse on accepted press (and on each repeat if enabled)
release_pulse  output  NUM_BUTTONS  1-cycle pulse on accepted release
long_pulse  output  NUM_BUTTONS  1-cycle pulse when press held LONG_PRESS_CYCLES

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high and is sampled on posedge clk.
- Reset: sync flops load the released pin level (1 if ACTIVE_LOW, else 0). All outputs 0, all counters 0, all FSMs IDLE. Reset asserted mid-operation aborts everything the same way; no pulse is emitted on reset entry or exit.
- Sync: s = second flop of btn_in, XORed with ACTIVE_LOW, so 1 = pressed.
- Debounce: stable_i internal, equal to btn_level[i]. While s != stable the debounce counter increments; when s == stable it clears to 0. On the cycle the counter equals DEBOUNCE_CYCLES-1 with s != stable, stable <= s and the counter clears. A glitch of any length shorter than DEBOUNCE_CYCLES restarts the count.
- Latency: a clean btn_in edge reaches btn_level and its pulse 2+DEBOUNCE_CYCLES cycles later. press_pulse/release_pulse assert in the same cycle btn_level changes.
- FSM per channel:
  - IDLE -> PRESSED on accepted press: press_pulse=1, hold counter cleared.
  - PRESSED: hold counter increments each cycle. When it reaches LONG_PRESS_CYCLES-1: long_pulse=1, go to HELD, hold counter cleared.
  - PRESSED or HELD -> IDLE on accepted release: release_pulse=1.
- Release takes priority over long/repeat in the same cycle. That cycle emits only release_pulse.
- Debounce glitches during PRESSED/HELD do not affect the hold counter.
- Pulses never overlap within a channel except the repeat case below, which cannot coincide with long_pulse.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
- A button held through reset release is reported as a fresh press after 2+DEBOUNCE_CYCLES cycles.
- Counters saturate-free by construction (CNT_W rule). No wrap-around is permitted.
- All outputs are registered.

Optional Feature:
AUTO_REPEAT_EN
- Defined: in HELD the hold counter counts to REPEAT_CYCLES-1, then press_pulse=1 and the counter clears, repeating until release. The first repeat fires REPEAT_CYCLES after long_pulse.
- Undefined: HELD is a pure wait state, no further pulses until release_pulse. REPEAT_CYCLES is unused and the repeat logic is absent.

Test Plan:
(Bench params: NUM_BUTTONS=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1.)
- Reset with btn_in=2'b11, hold 50 cycles -> all outputs 0 throughout.
- btn_in[0] 1->0 at cycle T, held 10 cycles -> btn_level[0]=1 and press_pulse[0]=1 for exactly one cycle at T+6; nothing on channel 1.
- btn_in[0] low for 3 cycles then high (bounce), repeated 5x -> no pulse, btn_level[0] stays 0.
- Hold btn_in[1] low 40 cycles -> press_pulse at T+6, long_pulse at T+26. On release, release_pulse 6 cycles after the rising edge. With AUTO_REPEAT_EN: press_pulse also at T+34.
- Both channels pressed on the same cycle -> press_pulse=2'b11 in one cycle. Assert reset mid-hold -> all outputs 0 next cycle, and press is re-reported 6 cycles after reset drops.
- Release accepted in the same cycle the hold counter hits LONG_PRESS_CYCLES-1 -> release_pulse only, no long_pulse.
